psum_acc_ctrl: RTL and testbench
================================

PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 13, the width of the pass-length field (maximum pass length 4096).
REQ-002 SHALL have: clk  input  1  clock, all logic on rising edge.
REQ-003 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have: cfg_len  input  LEN_W  psum words per pass, legal range 1..4096.
REQ-005 SHALL have: cfg_identity  input  1  identity-branch select, copied into info[13].
REQ-006 SHALL have: cfg_vld  input  1  and  cfg_rdy  output  1  forming the job-start handshake.
REQ-007 SHALL have: mac_data  input  64  MAC array result word.
REQ-008 SHALL have: mac_vld  input  1  and  mac_rdy  output  1  forming the MAC-side handshake.
REQ-009 SHALL have: acc_info  output  32,  acc_data  output  64,  acc_vld  output  1  and  acc_rdy  input  1  forming the accumulator-side handshake.
REQ-010 SHALL have: done  output  1  single-cycle job-complete pulse.
REQ-011 SHALL have: cfg_err  output  1  sticky illegal-config flag.

Function
REQ-012 SHALL implement the FSM states IDLE, PASS0 (buffer write), PASS1 (read-accumulate) and DONE.
REQ-013 SHALL drive cfg_rdy=1 only in IDLE.
REQ-014 SHALL, on a cfg handshake with a legal cfg_len, latch len and identity, clear addr to 0 and go to PASS0 on the next cycle.
REQ-015 SHALL, on a cfg handshake with cfg_len==0 or cfg_len>4096, set cfg_err, stay in IDLE and latch nothing.
REQ-016 SHALL pass data and handshakes through combinationally with zero latency: acc_vld=mac_vld&active, mac_rdy=acc_rdy&active, acc_data=mac_data, where active means PASS0 or PASS1.
REQ-017 SHALL drive acc_info as follows: [11:0]=addr; [12]=1 in PASS1 else 0; [13]=latched identity; [31:14]=0.
REQ-018 SHALL increment addr by 1 on each beat (acc_vld&acc_rdy).
REQ-019 SHALL, on a beat with addr==len-1 in PASS0, set addr to 0 and go to PASS1.
REQ-020 SHALL, on a beat with addr==len-1 in PASS1, go to DONE.
REQ-021 SHALL, in DONE, drive done=1 for exactly one cycle and then return to IDLE.
REQ-022 SHALL, when len==4096, let the last beat occur at addr 4095; the 12-bit addr never wraps within a pass.
REQ-023 SHALL hold addr and state when acc_rdy=0 or mac_vld=0; a stall of any length loses no beats.
REQ-024 SHALL ignore cfg_vld outside IDLE and hold cfg_rdy=0 there.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, force state IDLE, addr 0, len 0, identity 0 and cfg_err 0.
REQ-026 SHALL hold these output values during reset: cfg_rdy=1 (IDLE), mac_rdy=0, acc_vld=0, done=0, acc_info=0, cfg_err=0.
REQ-027 SHALL, on reset mid-job, abandon the job without emitting done; the next job starts clean from PASS0.

Configuration
REQ-028 SHALL, with PSUM_ACC_CTRL_PERF_EN defined, add outputs perf_beat_cnt (32 bits, counts beats) and perf_stall_cnt (32 bits, counts active cycles with mac_vld&~acc_rdy).
REQ-029 SHALL clear both counters on reset and on each cfg handshake, and let them saturate at all-ones.
REQ-030 SHALL, without PSUM_ACC_CTRL_PERF_EN, omit these ports and counters entirely; all other behaviour is unchanged.

Structure
REQ-031 SHALL take from shared package psum_acc_pkg: the info field positions (ADDR 11:0, PASS bit 12, IDENT bit 13), the state encoding and the maximum length constant 4096.
REQ-032 SHALL contain one sub-module, psum_acc_addr_cnt, holding the 12-bit address counter with inputs inc, clr and last-compare and output last.

Verification
REQ-033 SHALL cover basic job: cfg_len=4, identity=0, no stalls -> 4 beats with info 0x000..0x003, then 4 beats with info 0x1000..0x1003, done pulse exactly one cycle after the 8th beat.
REQ-034 SHALL cover identity job: cfg_len=2, identity=1 -> info 0x2000, 0x2001, 0x3000, 0x3001.
REQ-035 SHALL cover backpressure: cfg_len=3, acc_rdy low for 5 cycles mid-PASS0 -> mac_rdy=0 and addr held during the stall, sequence intact, perf_stall_cnt=5 when PERF enabled.
REQ-036 SHALL cover illegal configs: cfg_len=0 and cfg_len=4097 -> cfg_err=1, no acc_vld, state IDLE; a following cfg_len=1 job completes with 2 beats.
REQ-037 SHALL cover maximum length: cfg_len=4096 -> the last PASS0 beat carries info 0x0FFF, the first PASS1 beat carries 0x1000, the last carries 0x1FFF.
REQ-038 SHALL cover reset mid-PASS1 (addr=2, cfg_len=4) -> outputs take reset values, no done pulse, and a new cfg_len=1 job produces info 0x0000 then 0x1000.

Source files
------------

// File: rtl/psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulator controller: acc_info field
// positions, FSM state encoding and pass-length limits.
package psum_acc_pkg;

  localparam int unsigned ADDR_W         = 12;
  localparam int unsigned MAX_LEN        = 4096;
  localparam int unsigned INFO_ADDR_LSB  = 0;
  localparam int unsigned INFO_ADDR_MSB  = 11;
  localparam int unsigned INFO_PASS_BIT  = 12;
  localparam int unsigned INFO_IDENT_BIT = 13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS0 = 2'd1,
    ST_PASS1 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic len_is_legal(input logic [31:0] len);
    return (len != '0) && (len <= 32'(MAX_LEN));
  endfunction

endpackage

// File: rtl/psum_acc_ctrl_addr_cnt.sv
// 12-bit buffer address counter for one pass; o_last flags the final word.
module psum_acc_addr_cnt
  import psum_acc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_inc,
  input  logic              i_clr,
  input  logic [ADDR_W-1:0] i_last_addr,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == i_last_addr);

endmodule

// File: rtl/psum_acc_ctrl.sv
// Two-pass partial-sum accumulation controller (buffer write, then read-accumulate).
// Optional perf counters enabled by defining PSUM_ACC_CTRL_PERF_EN.
module psum_acc_ctrl
  import psum_acc_pkg::*;
#(
  parameter int unsigned LEN_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_identity,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [63:0]      mac_data,
  input  logic             mac_vld,
  output logic             mac_rdy,
  output logic [31:0]      acc_info,
  output logic [63:0]      acc_data,
  output logic             acc_vld,
  input  logic             acc_rdy,
  output logic             done,
  output logic             cfg_err
`ifdef PSUM_ACC_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_beat_cnt,
  output logic [31:0]      perf_stall_cnt
`endif
);

  state_t            r_state;
  logic [LEN_W-1:0]  r_len;
  logic              r_ident;
  logic              r_cfg_err;

  logic              w_active;
  logic              w_beat;
  logic              w_cfg_hs;
  logic              w_cfg_ok;
  logic              w_last;
  logic              w_addr_clr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] w_last_addr;

  assign w_active    = (r_state == ST_PASS0) || (r_state == ST_PASS1);
  assign w_beat      = mac_vld & acc_rdy & w_active;
  assign w_cfg_hs    = cfg_vld & (r_state == ST_IDLE);
  assign w_cfg_ok    = len_is_legal(32'(cfg_len));
  // len is 1..4096, so len-1 always fits the 12-bit address
  assign w_last_addr = ADDR_W'(r_len - 1'b1);
  assign w_addr_clr  = (w_cfg_hs & w_cfg_ok) | (w_beat & w_last & (r_state == ST_PASS0));

  psum_acc_addr_cnt u_addr_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inc       (w_beat),
    .i_clr       (w_addr_clr),
    .i_last_addr (w_last_addr),
    .o_addr      (w_addr),
    .o_last      (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_len     <= '0;
      r_ident   <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cfg_hs) begin
            if (w_cfg_ok) begin
              r_len   <= cfg_len;
              r_ident <= cfg_identity;
              r_state <= ST_PASS0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_PASS0: if (w_beat && w_last) r_state <= ST_PASS1;
        ST_PASS1: if (w_beat && w_last) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    acc_info                               = '0;
    acc_info[INFO_ADDR_MSB:INFO_ADDR_LSB]  = w_addr;
    acc_info[INFO_PASS_BIT]                = (r_state == ST_PASS1);
    acc_info[INFO_IDENT_BIT]               = r_ident;
  end

  assign cfg_rdy  = (r_state == ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign cfg_err  = r_cfg_err;
  assign acc_vld  = mac_vld & w_active;
  assign mac_rdy  = acc_rdy & w_active;
  assign acc_data = mac_data;

`ifdef PSUM_ACC_CTRL_PERF_EN
  logic [31:0] r_beat_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = w_active & mac_vld & ~acc_rdy;

  // Counters restart on every cfg handshake, legal or not
  always_ff @(posedge clk) begin
    if (!rst_n || w_cfg_hs) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_beat && (r_beat_cnt != '1))    r_beat_cnt  <= r_beat_cnt + 1'b1;
      if (w_stall && (r_stall_cnt != '1))  r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign perf_beat_cnt  = r_beat_cnt;
  assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Self-checking bench for psum_acc_ctrl; expected acc_info sequences come from
// a per-job list of (pass, addr, identity) words built from the job parameters.
module tb_psum_acc_ctrl;

  localparam int LEN_W = 13;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_identity;
  logic             cfg_vld;
  logic             cfg_rdy;
  logic [63:0]      mac_data;
  logic             mac_vld;
  logic             mac_rdy;
  logic [31:0]      acc_info;
  logic [63:0]      acc_data;
  logic             acc_vld;
  logic             acc_rdy;
  logic             done;
  logic             cfg_err;
`ifdef PSUM_ACC_CTRL_PERF_EN
  logic [31:0]      perf_beat_cnt;
  logic [31:0]      perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_cfg_err = 1'b0;

  always #5 clk = ~clk;

  psum_acc_ctrl #(.LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_len      (cfg_len),
    .cfg_identity (cfg_identity),
    .cfg_vld      (cfg_vld),
    .cfg_rdy      (cfg_rdy),
    .mac_data     (mac_data),
    .mac_vld      (mac_vld),
    .mac_rdy      (mac_rdy),
    .acc_info     (acc_info),
    .acc_data     (acc_data),
    .acc_vld      (acc_vld),
    .acc_rdy      (acc_rdy),
    .done         (done),
    .cfg_err      (cfg_err)
`ifdef PSUM_ACC_CTRL_PERF_EN
    ,
    .perf_beat_cnt  (perf_beat_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Runs one job; pct = per-cycle probability (%) of mac_vld and of acc_rdy.
  // stall_at/stall_n force acc_rdy low with mac_vld high before beat stall_at.
  // abort_at >= 0 returns just before that beat index, leaving the job running.
  task automatic run_job(input int len, input bit ident, input int pct,
                         input int stall_at, input int stall_n, input int abort_at);
    logic [31:0] exp_q[$];
    logic [31:0] exp_info;
    int k, cyc, stall_left, n_stall;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < len; a++)
        exp_q.push_back((32'(ident) << 13) | (32'(p) << 12) | 32'(a));
    mac_vld      = 1'b0;
    cfg_len      = LEN_W'(len);
    cfg_identity = ident;
    cfg_vld      = 1'b1;
    n_checks++;
    if (cfg_rdy !== 1'b1) begin
      n_fail++; $display("FAIL cfg_rdy_idle: got %b expected 1", cfg_rdy);
    end
    @(posedge clk); #1;
    cfg_vld    = 1'b0;
    k          = 0;
    cyc        = 0;
    stall_left = stall_n;
    n_stall    = 0;
    while (k < 2 * len) begin
      if (k == abort_at) return;
      if (cyc > 40 * len + 100) begin
        n_checks++; n_fail++;
        $display("FAIL job_timeout: got %0d beats expected %0d", k, 2 * len);
        return;
      end
      mac_data = {$urandom, $urandom};
      cfg_vld  = 1'($urandom_range(0, 1));
      cfg_len  = LEN_W'($urandom_range(0, 5000));
      if (k == stall_at && stall_left > 0) begin
        mac_vld = 1'b1;
        acc_rdy = 1'b0;
        stall_left--;
      end else begin
        mac_vld = ($urandom_range(0, 99) < pct);
        acc_rdy = ($urandom_range(0, 99) < pct);
      end
      #1;
      exp_info = exp_q[k];
      n_checks += 6;
      if (acc_info !== exp_info) begin
        n_fail++; $display("FAIL info: got %h expected %h (beat %0d)", acc_info, exp_info, k);
      end
      if (acc_vld !== mac_vld) begin
        n_fail++; $display("FAIL acc_vld: got %b expected %b", acc_vld, mac_vld);
      end
      if (mac_rdy !== acc_rdy) begin
        n_fail++; $display("FAIL mac_rdy: got %b expected %b", mac_rdy, acc_rdy);
      end
      if (acc_data !== mac_data) begin
        n_fail++; $display("FAIL acc_data: got %h expected %h", acc_data, mac_data);
      end
      if (cfg_rdy !== 1'b0) begin
        n_fail++; $display("FAIL cfg_rdy_busy: got %b expected 0", cfg_rdy);
      end
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL done_early: got %b expected 0", done);
      end
      if (mac_vld && acc_rdy) k++;
      else if (mac_vld) n_stall++;
      @(posedge clk); #1;
      cyc++;
    end
    mac_vld = 1'b0;
    cfg_vld = 1'b0;
    n_checks += 2;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL done_pulse: got %b expected 1", done);
    end
    if (cfg_err !== exp_cfg_err) begin
      n_fail++; $display("FAIL cfg_err_job: got %b expected %b", cfg_err, exp_cfg_err);
    end
`ifdef PSUM_ACC_CTRL_PERF_EN
    n_checks += 2;
    if (perf_beat_cnt !== 32'(2 * len)) begin
      n_fail++; $display("FAIL perf_beat: got %0d expected %0d", perf_beat_cnt, 2 * len);
    end
    if (perf_stall_cnt !== 32'(n_stall)) begin
      n_fail++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cnt, n_stall);
    end
`endif
    @(posedge clk); #1;
    n_checks += 2;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL done_width: got %b expected 0", done);
    end
    if (cfg_rdy !== 1'b1) begin
      n_fail++; $display("FAIL cfg_rdy_return: got %b expected 1", cfg_rdy);
    end
  endtask

  task automatic check_reset_outputs();
    n_checks += 6;
    if (cfg_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rst_cfg_rdy: got %b expected 1", cfg_rdy);
    end
    if (mac_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mac_rdy: got %b expected 0", mac_rdy);
    end
    if (acc_vld !== 1'b0) begin
      n_fail++; $display("FAIL rst_acc_vld: got %b expected 0", acc_vld);
    end
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL rst_done: got %b expected 0", done);
    end
    if (acc_info !== 32'h0) begin
      n_fail++; $display("FAIL rst_acc_info: got %h expected 00000000", acc_info);
    end
    if (cfg_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_cfg_err: got %b expected 0", cfg_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_vld = 1'b0; cfg_len = '0; cfg_identity = 1'b0;
    mac_vld = 1'b1; acc_rdy = 1'b1; mac_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1; mac_vld = 1'b0;
    exp_cfg_err = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_job(4, 1'b0, 100, -1, 0, -1);
  endtask

  task automatic test_identity();
    run_job(2, 1'b1, 100, -1, 0, -1);
  endtask

  task automatic test_backpressure();
    run_job(3, 1'b0, 100, 1, 5, -1);
  endtask

  task automatic test_illegal_cfg();
    logic [LEN_W-1:0] bad [2];
    bad[0] = '0;
    bad[1] = LEN_W'(4097);
    foreach (bad[i]) begin
      mac_vld = 1'b1; acc_rdy = 1'b1;
      cfg_len = bad[i]; cfg_identity = 1'b1; cfg_vld = 1'b1;
      @(posedge clk); #1;
      cfg_vld = 1'b0;
      repeat (2) begin
        n_checks += 4;
        if (cfg_err !== 1'b1) begin
          n_fail++; $display("FAIL ill_cfg_err: got %b expected 1", cfg_err);
        end
        if (cfg_rdy !== 1'b1) begin
          n_fail++; $display("FAIL ill_idle: got %b expected 1", cfg_rdy);
        end
        if (acc_vld !== 1'b0) begin
          n_fail++; $display("FAIL ill_acc_vld: got %b expected 0", acc_vld);
        end
        if (mac_rdy !== 1'b0) begin
          n_fail++; $display("FAIL ill_mac_rdy: got %b expected 0", mac_rdy);
        end
        @(posedge clk); #1;
      end
    end
    mac_vld = 1'b0;
    exp_cfg_err = 1'b1;
    run_job(1, 1'b0, 100, -1, 0, -1);
  endtask

  task automatic test_random_jobs();
    repeat (6) run_job($urandom_range(1, 40), 1'($urandom_range(0, 1)), 60, -1, 0, -1);
  endtask

  task automatic test_back_to_back();
    run_job(5, 1'b1, 100, -1, 0, -1);
    run_job(3, 1'b0, 100, -1, 0, -1);
  endtask

  task automatic test_max_len();
    run_job(4096, 1'b0, 100, -1, 0, -1);
  endtask

  task automatic test_reset_mid_job();
    run_job(4, 1'b0, 100, -1, 0, 6);
    n_checks++;
    if (acc_info !== 32'h0000_1002) begin
      n_fail++; $display("FAIL mid_job_info: got %h expected 00001002", acc_info);
    end
    rst_n = 1'b0; mac_vld = 1'b1; acc_rdy = 1'b1; cfg_vld = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs();
    rst_n = 1'b1; mac_vld = 1'b0;
    exp_cfg_err = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++; $display("FAIL abandon_done: got %b expected 0", done);
      end
    end
    run_job(1, 1'b0, 100, -1, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_backpressure();
    test_illegal_cfg();
    test_random_jobs();
    test_back_to_back();
    test_max_len();
    test_reset_mid_job();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish expected finish within 5ms");
    $fatal(1, "watchdog expired");
  end

endmodule
